// File: rtl/pipe_stall_ctrl_if.sv
// Purpose: hazard request / stall control bundle between the pipeline stages and pipe_stall_ctrl.
// Latency: none, wiring only.
// Backpressure: stall[] is the backpressure; the master side must hold a stage while its bit is 1.
// Ports: stallreq_id, ex_mc_start, ex_mc_cycles, mem_req, mem_ack (pipeline -> controller);
//        stall, ex_mc_done, mem_timeout, ex_busy, stall_cnt (controller -> pipeline).
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             stallreq_id;
    logic             ex_mc_start;
    logic [CNT_W-1:0] ex_mc_cycles;
    logic             mem_req;
    logic             mem_ack;
    logic [5:0]       stall;
    logic             ex_mc_done;
    logic             mem_timeout;
    logic             ex_busy;
    logic [31:0]      stall_cnt;

    // Pipeline side: raises hazard requests, obeys the stall vector.
    modport master (
        output stallreq_id, ex_mc_start, ex_mc_cycles, mem_req, mem_ack,
        input  stall, ex_mc_done, mem_timeout, ex_busy, stall_cnt
    );

    // Controller side.
    modport slave (
        input  stallreq_id, ex_mc_start, ex_mc_cycles, mem_req, mem_ack,
        output stall, ex_mc_done, mem_timeout, ex_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Purpose: merges ID load-use, EX multi-cycle and MEM wait hazards into the 6-bit pipeline stall vector.
// Latency: stall is combinational from registered state plus current requests; stall_cnt lags by one edge.
// Backpressure: MEM > EX > ID priority; a MEM wait is force-released after MEM_TIMEOUT cycles.
// Ports: clk, rst (sync, active-low), ctl (pipe_stall_ctrl_if.slave).
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   ctl
);
    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_BUSY = 2'd1,
        EX_DONE = 2'd2
    } ex_state_e;

    localparam logic [7:0]       MEM_LIMIT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    ex_state_e        ex_state_q, ex_state_d;
    logic [CNT_W-1:0] ex_cnt_q, ex_cnt_d;
    logic [7:0]       mem_wait_cnt_q, mem_wait_cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic       mem_pend;
    logic       mem_stall;
    logic       mem_tmo;
    logic       ex_entry;
    logic       ex_stall;
    logic [5:0] stall_v;

    always_comb begin
        mem_pend       = 1'b0;
        mem_stall      = 1'b0;
        mem_tmo        = 1'b0;
        ex_entry       = 1'b0;
        ex_stall       = 1'b0;
        stall_v        = STALL_NONE;
        mem_wait_cnt_d = 8'd0;
        ex_state_d     = ex_state_q;
        ex_cnt_d       = ex_cnt_q;
        stall_cnt_d    = stall_cnt_q;

        // MEM wait watchdog: an ack in the limit cycle suppresses the timeout.
        mem_pend  = ctl.mem_req & ~ctl.mem_ack;
        mem_stall = mem_pend & (mem_wait_cnt_q != MEM_LIMIT);
        mem_tmo   = mem_pend & (mem_wait_cnt_q == MEM_LIMIT);
        if (mem_stall) begin
            mem_wait_cnt_d = mem_wait_cnt_q + 8'd1;
        end

        // The entry cycle itself already stalls EX, so it counts as cycle 1 of the op.
        ex_entry = (ex_state_q == EX_IDLE) & ctl.ex_mc_start & (ctl.ex_mc_cycles >= CNT_TWO);
        ex_stall = ex_entry | (ex_state_q == EX_BUSY);

        if (mem_stall) begin
            stall_v = STALL_MEM;
        end else if (ex_stall) begin
            stall_v = STALL_EX;
        end else if (ctl.stallreq_id) begin
            stall_v = STALL_ID;
        end

        // ex_cnt holds the BUSY cycles still to go, including the current one.
        // A 2-cycle op has no BUSY cycle and goes straight to DONE.
        case (ex_state_q)
            EX_IDLE: begin
                if (ex_entry) begin
                    ex_cnt_d   = ctl.ex_mc_cycles - CNT_TWO;
                    ex_state_d = (ctl.ex_mc_cycles == CNT_TWO) ? EX_DONE : EX_BUSY;
                end
            end
            EX_BUSY: begin
                if (ex_cnt_q <= CNT_ONE) begin
                    ex_cnt_d   = '0;
                    ex_state_d = EX_DONE;
                end else begin
                    ex_cnt_d = ex_cnt_q - CNT_ONE;
                end
            end
            EX_DONE: begin
                // Result is held in EX until the EX boundary is actually released.
                if (!stall_v[3]) begin
                    ex_state_d = EX_IDLE;
                end
            end
            default: begin
                ex_state_d = EX_IDLE;
                ex_cnt_d   = '0;
            end
        endcase

        if (stall_v[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_state_q     <= EX_IDLE;
            ex_cnt_q       <= '0;
            mem_wait_cnt_q <= 8'd0;
            stall_cnt_q    <= 32'd0;
        end else begin
            ex_state_q     <= ex_state_d;
            ex_cnt_q       <= ex_cnt_d;
            mem_wait_cnt_q <= mem_wait_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    // Outputs are masked while reset is held so an aborted op or wait never pulses.
    assign ctl.stall       = rst ? stall_v : STALL_NONE;
    assign ctl.ex_mc_done  = rst & (ex_state_q == EX_DONE);
    assign ctl.mem_timeout = rst & mem_tmo;
    assign ctl.ex_busy     = rst & (ex_state_q != EX_IDLE);
    assign ctl.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Purpose: self-checking bench for pipe_stall_ctrl (default instance plus a MEM_TIMEOUT=4 instance).
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: n/a; expected values are queued per cycle and popped against sampled outputs.
module tb_pipe_stall_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(6)) bus ();
    pipe_stall_ctrl_if #(.CNT_W(6)) bus_to ();

    assign bus_to.stallreq_id  = bus.stallreq_id;
    assign bus_to.ex_mc_start  = bus.ex_mc_start;
    assign bus_to.ex_mc_cycles = bus.ex_mc_cycles;
    assign bus_to.mem_req      = bus.mem_req;
    assign bus_to.mem_ack      = bus.mem_ack;

    pipe_stall_ctrl #(.MEM_TIMEOUT(16), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(6)) dut_to (
        .clk (clk),
        .rst (rst),
        .ctl (bus_to)
    );

    typedef struct packed {
        logic [5:0]  stall;
        logic        done;
        logic        tmo;
        logic        busy;
        logic [31:0] cnt;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        act_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned exp_cnt = 0;

    // One clock cycle: drive inputs, queue the expectation, sample the chosen DUT.
    // Expected stall_cnt is the number of earlier cycles expected to stall the PC.
    task automatic cyc(input logic r, input logic id, input logic st, input logic [5:0] n,
                       input logic rq, input logic ak, input logic [5:0] es,
                       input logic ed, input logic et, input logic eb, input bit to);
        obs_t e;
        obs_t a;
        @(posedge clk);
        #1;
        rst              = r;
        bus.stallreq_id  = id;
        bus.ex_mc_start  = st;
        bus.ex_mc_cycles = n;
        bus.mem_req      = rq;
        bus.mem_ack      = ak;
        e.stall = es;
        e.done  = ed;
        e.tmo   = et;
        e.busy  = eb;
        e.cnt   = to ? 32'd0 : 32'(exp_cnt);
        exp_q.push_back(e);
        @(negedge clk);
        if (to) begin
            a.stall = bus_to.stall;
            a.done  = bus_to.ex_mc_done;
            a.tmo   = bus_to.mem_timeout;
            a.busy  = bus_to.ex_busy;
            a.cnt   = 32'd0;
        end else begin
            a.stall = bus.stall;
            a.done  = bus.ex_mc_done;
            a.tmo   = bus.mem_timeout;
            a.busy  = bus.ex_busy;
            a.cnt   = bus.stall_cnt;
        end
        act_q.push_back(a);
        if (!r) exp_cnt = 0;
        else if (es[0]) exp_cnt++;
    endtask

    task automatic test_reset();
        int k = 0;
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 6'd5, 1, 0, 6'b000000, 0, 0, 0, 0);
        cyc(1, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        cyc(1, 1, 0, 6'd0, 0, 0, 6'b000111, 0, 0, 0, 0);
        cyc(1, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t a = act_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got stall=%b done=%b tmo=%b busy=%b cnt=%0d, want stall=%b done=%b tmo=%b busy=%b cnt=%0d",
                         k, a.stall, a.done, a.tmo, a.busy, a.cnt, e.stall, e.done, e.tmo, e.busy, e.cnt);
            end
            k++;
        end
    endtask

    task automatic test_multicycle();
        int k = 0;
        cyc(0, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        // 5-cycle op: entry + 3 BUSY stall, then DONE without stall
        cyc(1, 0, 1, 6'd5, 0, 0, 6'b001111, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 6'd5, 0, 0, 6'b001111, 0, 0, 1, 0);
        cyc(1, 0, 1, 6'd5, 0, 0, 6'b000000, 1, 0, 1, 0);
        cyc(1, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        // 2-cycle op: entry stall only, then DONE
        cyc(1, 0, 1, 6'd2, 0, 0, 6'b001111, 0, 0, 0, 0);
        cyc(1, 0, 1, 6'd2, 0, 0, 6'b000000, 1, 0, 1, 0);
        // 1- and 0-cycle ops are single-cycle: no stall
        cyc(1, 0, 1, 6'd1, 0, 0, 6'b000000, 0, 0, 0, 0);
        cyc(1, 0, 1, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        cyc(1, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t a = act_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL multicycle[%0d]: got stall=%b done=%b tmo=%b busy=%b cnt=%0d, want stall=%b done=%b tmo=%b busy=%b cnt=%0d",
                         k, a.stall, a.done, a.tmo, a.busy, a.cnt, e.stall, e.done, e.tmo, e.busy, e.cnt);
            end
            k++;
        end
    endtask

    task automatic test_mem_ack();
        int k = 0;
        cyc(0, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 6'd0, 1, 0, 6'b011111, 0, 0, 0, 0);
        cyc(1, 0, 0, 6'd0, 1, 1, 6'b000000, 0, 0, 0, 0);
        // MEM outranks ID; after the ack ID passes through
        for (int i = 0; i < 2; i++) cyc(1, 1, 0, 6'd0, 1, 0, 6'b011111, 0, 0, 0, 0);
        cyc(1, 1, 0, 6'd0, 1, 1, 6'b000111, 0, 0, 0, 0);
        cyc(1, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t a = act_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL mem_ack[%0d]: got stall=%b done=%b tmo=%b busy=%b cnt=%0d, want stall=%b done=%b tmo=%b busy=%b cnt=%0d",
                         k, a.stall, a.done, a.tmo, a.busy, a.cnt, e.stall, e.done, e.tmo, e.busy, e.cnt);
            end
            k++;
        end
    endtask

    task automatic test_ex_overlap_mem();
        int k = 0;
        cyc(0, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        cyc(1, 0, 0, 6'd0, 1, 0, 6'b011111, 0, 0, 0, 0);
        cyc(1, 0, 1, 6'd3, 1, 0, 6'b011111, 0, 0, 0, 0);
        cyc(1, 0, 1, 6'd3, 1, 0, 6'b011111, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 6'd3, 1, 0, 6'b011111, 1, 0, 1, 0);
        cyc(1, 0, 1, 6'd3, 1, 1, 6'b000000, 1, 0, 1, 0);
        cyc(1, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        cyc(1, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t a = act_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL ex_overlap_mem[%0d]: got stall=%b done=%b tmo=%b busy=%b cnt=%0d, want stall=%b done=%b tmo=%b busy=%b cnt=%0d",
                         k, a.stall, a.done, a.tmo, a.busy, a.cnt, e.stall, e.done, e.tmo, e.busy, e.cnt);
            end
            k++;
        end
    endtask

    task automatic test_reset_midop();
        int k = 0;
        cyc(0, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        cyc(1, 0, 1, 6'd5, 0, 0, 6'b001111, 0, 0, 0, 0);
        cyc(1, 0, 1, 6'd5, 0, 0, 6'b001111, 0, 0, 1, 0);
        cyc(0, 0, 1, 6'd5, 0, 0, 6'b000000, 0, 0, 0, 0);
        cyc(1, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        cyc(1, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        // MEM wait aborted by reset restarts cleanly
        cyc(1, 0, 0, 6'd0, 1, 0, 6'b011111, 0, 0, 0, 0);
        cyc(0, 0, 0, 6'd0, 1, 0, 6'b000000, 0, 0, 0, 0);
        cyc(1, 0, 0, 6'd0, 1, 0, 6'b011111, 0, 0, 0, 0);
        cyc(1, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t a = act_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL reset_midop[%0d]: got stall=%b done=%b tmo=%b busy=%b cnt=%0d, want stall=%b done=%b tmo=%b busy=%b cnt=%0d",
                         k, a.stall, a.done, a.tmo, a.busy, a.cnt, e.stall, e.done, e.tmo, e.busy, e.cnt);
            end
            k++;
        end
    endtask

    // Runs last: observes the MEM_TIMEOUT=4 instance only.
    task automatic test_mem_timeout();
        int k = 0;
        cyc(0, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 6'd0, 1, 0, 6'b011111, 0, 0, 0, 1);
        cyc(1, 0, 0, 6'd0, 1, 0, 6'b000000, 0, 1, 0, 1);
        // wait counter cleared: a fresh 4-cycle window, ack in the limit cycle wins
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 6'd0, 1, 0, 6'b011111, 0, 0, 0, 1);
        cyc(1, 0, 0, 6'd0, 1, 1, 6'b000000, 0, 0, 0, 1);
        cyc(1, 0, 0, 6'd0, 0, 0, 6'b000000, 0, 0, 0, 1);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t a = act_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL mem_timeout[%0d]: got stall=%b done=%b tmo=%b busy=%b, want stall=%b done=%b tmo=%b busy=%b",
                         k, a.stall, a.done, a.tmo, a.busy, e.stall, e.done, e.tmo, e.busy);
            end
            k++;
        end
    endtask

    initial begin
        rst              = 1'b0;
        bus.stallreq_id  = 1'b1;
        bus.ex_mc_start  = 1'b1;
        bus.ex_mc_cycles = 6'd5;
        bus.mem_req      = 1'b1;
        bus.mem_ack      = 1'b0;
        test_reset();
        test_multicycle();
        test_mem_ack();
        test_ex_overlap_mem();
        test_reset_midop();
        test_mem_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
